wts_tone_generator_mc: RTL

Parametrised, time-multiplexed wave-table tone generator for NUM_CH channels.
- One shared step datapath; per-channel phase counter and wave address are held in registers.
- Each cycle an external sequencer presents a slot number. The block advances that channel's state and emits the wave-table read address one cycle later.
- Compared with the fixed 5-channel generator, it adds: configurable channel count and widths, per-channel key-on, and a one-shot (play-once) mode with end-of-wave flags.

---
 rtl/wts_tone_generator_mc_if.sv | 32 +++
 rtl/wts_tone_generator_mc.sv | 88 ++++++++
 2 files changed

// File: rtl/wts_tone_generator_mc_if.sv
// wts_tone_generator_mc_if: slot, register and key-on inputs plus the registered
// wave-table address outputs of the time-multiplexed tone generator.
interface wts_tone_generator_mc_if #(
  parameter int NUM_CH = 5,
  parameter int CH_W   = 3,
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 7
);
  logic              slot_valid;
  logic [CH_W-1:0]   slot;
  logic [FREQ_W-1:0] reg_frequency_count;
  logic [1:0]        reg_wave_length;
  logic              reg_one_shot;
  logic [NUM_CH-1:0] key_on;
  logic              key_reset_addr;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [ADDR_W-1:0] wave_address;
  logic              step;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] end_flag;
  modport master (
    output slot_valid, slot, reg_frequency_count, reg_wave_length, reg_one_shot,
           key_on, key_reset_addr,
    input  out_valid, out_ch, wave_address, step, busy, end_flag
  );
  modport slave (
    input  slot_valid, slot, reg_frequency_count, reg_wave_length, reg_one_shot,
           key_on, key_reset_addr,
    output out_valid, out_ch, wave_address, step, busy, end_flag
  );
endinterface

// File: rtl/wts_tone_generator_mc.sv
// wts_tone_generator_mc: time-multiplexed wave-table tone generator; one shared step
// datapath services the presented slot and emits its wave address one cycle later.
module wts_tone_generator_mc #(
  parameter int NUM_CH = 5,
  parameter int CH_W   = 3,
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 7
) (
  input logic clk,
  input logic nreset,
  wts_tone_generator_mc_if.slave bus
);
  logic [FREQ_W-1:0] count_q [NUM_CH];
  logic [FREQ_W-1:0] count_d [NUM_CH];
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [ADDR_W-1:0] addr_d [NUM_CH];
  logic [NUM_CH-1:0] busy_q, busy_d, end_q, end_d;
  logic              out_valid_q, out_valid_d, step_q, step_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [ADDR_W-1:0] wa_q, wa_d, mask, nxt;
  logic              svc;
  assign svc  = bus.slot_valid && (32'(bus.slot) < NUM_CH);
  // length code 3 spans the full address width; each lower code halves it
  assign mask = {ADDR_W{1'b1}} >> (2'd3 - bus.reg_wave_length);
  always_comb begin
    count_d     = count_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    end_d       = end_q;
    out_valid_d = svc;
    out_ch_d    = svc ? bus.slot : out_ch_q;
    wa_d        = wa_q;
    step_d      = 1'b0;
    nxt         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (svc && 32'(bus.slot) == i && !bus.key_on[i] && busy_q[i]) begin
        if (count_q[i] >= bus.reg_frequency_count) begin
          count_d[i] = '0;
          step_d     = 1'b1;
          nxt        = (addr_q[i] + ADDR_W'(1)) & mask;
          if (bus.reg_one_shot && nxt == '0) begin
            busy_d[i] = 1'b0;
            end_d[i]  = 1'b1;
          end else begin
            addr_d[i] = nxt;
          end
        end else begin
          count_d[i] = count_q[i] + FREQ_W'(1);
        end
      end
      // sampled before key_on so a colliding restart still reports the pre-key address
      if (svc && 32'(bus.slot) == i) wa_d = addr_d[i];
      if (bus.key_on[i]) begin
        count_d[i] = '0;
        busy_d[i]  = 1'b1;
        end_d[i]   = 1'b0;
        addr_d[i]  = bus.key_reset_addr ? '0 : addr_d[i];
      end
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_q     <= '{default: '0};
      addr_q      <= '{default: '0};
      busy_q      <= '0;
      end_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      wa_q        <= '0;
      step_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      end_q       <= end_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      wa_q        <= wa_d;
      step_q      <= step_d;
    end
  end
  assign bus.out_valid    = out_valid_q;
  assign bus.out_ch       = out_ch_q;
  assign bus.wave_address = wa_q;
  assign bus.step         = step_q;
  assign bus.busy         = busy_q;
  assign bus.end_flag     = end_q;
endmodule
